// File: rtl/crc_sched_if.sv
// crc_sched_if: bundle of the requester, result and CRC-engine register
// signals around crc_sched.
//   req_*     : two requester beat streams (valid/ready/last/data/size)
//   cfg_*     : per-requester CRC configuration (poly/init/xor/reflect)
//   res_*     : result handshake (valid/ready/crc/id)
//   eng_*     : CRC engine register port (cs/rs/wrl/d driven, q returned)
// Modport slave is taken by crc_sched; master is the surrounding system.
interface crc_sched_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_last;
    logic [1:0][31:0] req_data;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] cfg_poly;
    logic [1:0][31:0] cfg_init;
    logic [1:0][31:0] cfg_xor;
    logic [1:0][1:0]  cfg_refl;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_crc;
    logic             res_id;
    logic             eng_cs;
    logic [1:0]       eng_rs;
    logic [3:0]       eng_wrl;
    logic [31:0]      eng_d;
    logic [31:0]      eng_q;

    modport slave (
        input  req_valid, req_last, req_data, req_size,
        input  cfg_poly, cfg_init, cfg_xor, cfg_refl,
        input  res_ready, eng_q,
        output req_ready, res_valid, res_crc, res_id,
        output eng_cs, eng_rs, eng_wrl, eng_d
    );

    modport master (
        output req_valid, req_last, req_data, req_size,
        output cfg_poly, cfg_init, cfg_xor, cfg_refl,
        output res_ready, eng_q,
        input  req_ready, res_valid, res_crc, res_id,
        input  eng_cs, eng_rs, eng_wrl, eng_d
    );
endinterface

// File: rtl/crc_sched.sv
// crc_sched: arbitrates two packet requesters onto one shared CRC engine.
// A granted packet loads init and polynomial into the engine, streams its
// beats (waiting on the engine status bit after each), reads the result
// back, XORs it with the owner's final-XOR value and offers it on res_*.
// Ports:
//   clk   : clock, everything on posedge
//   rst_n : synchronous active-low reset
//   bus   : crc_sched_if.slave (requesters, config, result, engine port)
// Parameter RR: 1 = round-robin between requesters, 0 = requester 0 wins.
module crc_sched #(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    crc_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_INIT = 3'd1,
        LD_POLY = 3'd2,
        WR_DATA = 3'd3,
        WAIT    = 3'd4,
        RD_RES  = 3'd5,
        OUT     = 3'd6
    } state_t;

    // Engine byte-lane write mask for a beat size code.
    function automatic logic [3:0] size_to_wrl(input logic [1:0] sz);
        logic [3:0] wrl;
        case (sz)
            2'd0:    wrl = 4'b0001;
            2'd1:    wrl = 4'b0011;
            default: wrl = 4'b1111;
        endcase
        return wrl;
    endfunction

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        beat_last_q, beat_last_d;
    logic [31:0] res_crc_q, res_crc_d;
    logic        res_id_q, res_id_d;

    logic        grant_s;
    logic [1:0]  req_ready_s;
    logic        eng_cs_s;
    logic [1:0]  eng_rs_s;
    logic [3:0]  eng_wrl_s;
    logic [31:0] eng_d_s;

    // Arbitration: with both valid, round-robin picks the one not granted
    // last; fixed priority always picks requester 0.
    always_comb begin
        case (bus.req_valid)
            2'b11:   grant_s = RR ? ~last_grant_q : 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b01:   grant_s = 1'b0;
            default: grant_s = 1'b0;
        endcase
    end

    // Next-state and engine/requester outputs for the packet sequencer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_last_d  = beat_last_q;
        res_crc_d    = res_crc_q;
        res_id_d     = res_id_q;
        req_ready_s  = 2'b00;
        eng_cs_s     = 1'b0;
        eng_rs_s     = 2'b00;
        eng_wrl_s    = 4'b0000;
        eng_d_s      = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    state_d      = LD_INIT;
                end else begin
                    state_d      = IDLE;
                end
            end
            LD_INIT: begin
                eng_cs_s  = 1'b1;
                eng_rs_s  = 2'b00;
                eng_wrl_s = 4'b1111;
                eng_d_s   = bus.cfg_init[owner_q];
                state_d   = LD_POLY;
            end
            LD_POLY: begin
                eng_cs_s  = 1'b1;
                eng_rs_s  = 2'b01;
                eng_wrl_s = 4'b1111;
                eng_d_s   = bus.cfg_poly[owner_q];
                state_d   = WR_DATA;
            end
            WR_DATA: begin
                // Ready is offered whether or not the owner has a beat;
                // a missing beat just leaves the engine port idle.
                req_ready_s = owner_q ? 2'b10 : 2'b01;
                if (bus.req_valid[owner_q]) begin
                    eng_cs_s    = 1'b1;
                    eng_rs_s    = {1'b1, bus.cfg_refl[owner_q][0]};
                    eng_wrl_s   = size_to_wrl(bus.req_size[owner_q]);
                    eng_d_s     = bus.req_data[owner_q];
                    beat_last_d = bus.req_last[owner_q];
                    state_d     = WAIT;
                end else begin
                    state_d     = WR_DATA;
                end
            end
            WAIT: begin
                // Status read: eng_q[0] reports the engine idle again.
                eng_cs_s  = 1'b1;
                eng_rs_s  = 2'b01;
                eng_wrl_s = 4'b0000;
                if (bus.eng_q[0]) begin
                    state_d = beat_last_q ? RD_RES : WR_DATA;
                end else begin
                    state_d = WAIT;
                end
            end
            RD_RES: begin
                eng_cs_s  = 1'b1;
                eng_rs_s  = {bus.cfg_refl[owner_q][1], 1'b0};
                eng_wrl_s = 4'b0000;
                res_crc_d = bus.eng_q ^ bus.cfg_xor[owner_q];
                res_id_d  = owner_q;
                state_d   = OUT;
            end
            OUT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset leaves requester 0 favoured next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_last_q  <= 1'b0;
            res_crc_q    <= 32'h0000_0000;
            res_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_last_q  <= beat_last_d;
            res_crc_q    <= res_crc_d;
            res_id_q     <= res_id_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.res_valid = (state_q == OUT);
    assign bus.res_crc   = res_crc_q;
    assign bus.res_id    = res_id_q;
    assign bus.eng_cs    = eng_cs_s;
    assign bus.eng_rs    = eng_rs_s;
    assign bus.eng_wrl   = eng_wrl_s;
    assign bus.eng_d     = eng_d_s;

endmodule
